// File: rtl/ldr_frame_sequencer.sv
// Frame-level sequencer for the Levinson-Durbin core: buffers ORDER+1 R words, pulses core reset,
// holds start until done, then streams the captured A words. Optional SOLVE watchdog: LDR_SEQ_TIMEOUT_EN.
module ldr_frame_sequencer #(
  parameter int W       = 16,
  parameter int ORDER   = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   r_valid,
  input  logic [W-1:0]           r_data,
  input  logic                   r_last,
  output logic                   r_ready,
  output logic                   ldr_rst,
  output logic                   ldr_start,
  output logic [(ORDER+1)*W-1:0] ldr_r,
  input  logic [(ORDER+1)*W-1:0] ldr_a,
  input  logic                   ldr_done,
  output logic                   a_valid,
  output logic [W-1:0]           a_data,
  output logic                   a_last,
  input  logic                   a_ready,
  output logic                   busy,
  output logic                   frame_err,
  output logic [15:0]            cycles,
  output logic [15:0]            frames
);
  localparam int N = ORDER + 1;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(ORDER);

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_SKIP,
    ST_CORE_RST,
    ST_SOLVE,
    ST_DRAIN
  } state_t;

  state_t        state_reg;
  logic [KW-1:0] k_reg;
  logic [KW-1:0] k_inc;
  logic          rst_cnt_reg;
  logic [15:0]   solve_cnt_reg;
  logic [15:0]   cycles_reg;
  logic [15:0]   frames_reg;
  logic          ready_reg;
  logic          ldr_rst_reg;
  logic          ldr_start_reg;
  logic          a_valid_reg;
  logic          a_last_reg;
  logic [W-1:0]  a_data_reg;
  logic          busy_reg;
  logic          frame_err_reg;
  logic [N*W-1:0] r_buf_reg;
  logic [N*W-1:0] cap_reg;

  logic          r_fire;
  logic          a_fire;
  logic          load_wr;
  logic          cap_en;
  logic [N-1:0]  slot_we;

  assign r_fire  = r_valid & ready_reg;
  assign a_fire  = a_valid_reg & a_ready;
  assign load_wr = (state_reg == ST_LOAD) & r_fire;
  assign cap_en  = (state_reg == ST_SOLVE) & ldr_done;
  assign k_inc   = k_reg + 1'b1;

  // One write strobe per R slot; SKIP never produces a strobe, so discarded words cannot land in the buffer.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slot_we
      assign slot_we[gi] = load_wr && (k_reg == KW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_reg <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (slot_we[i]) begin
          r_buf_reg[i*W +: W] <= r_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cap_en) begin
      cap_reg <= ldr_a;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_LOAD;
      k_reg         <= '0;
      rst_cnt_reg   <= 1'b0;
      solve_cnt_reg <= '0;
      cycles_reg    <= '0;
      frames_reg    <= '0;
      ready_reg     <= 1'b1;
      ldr_rst_reg   <= 1'b1;
      ldr_start_reg <= 1'b0;
      a_valid_reg   <= 1'b0;
      a_last_reg    <= 1'b0;
      a_data_reg    <= '0;
      busy_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      case (state_reg)
        ST_LOAD: begin
          ldr_rst_reg <= 1'b0;
          if (r_fire) begin
            if (k_reg == K_LAST) begin
              k_reg <= '0;
              if (r_last) begin
                state_reg   <= ST_CORE_RST;
                ready_reg   <= 1'b0;
                ldr_rst_reg <= 1'b1;
                rst_cnt_reg <= 1'b0;
                busy_reg    <= 1'b1;
              end else begin
                frame_err_reg <= 1'b1;
                state_reg     <= ST_SKIP;
                busy_reg      <= 1'b1;
              end
            end else if (r_last) begin
              frame_err_reg <= 1'b1;
              k_reg         <= '0;
            end else begin
              k_reg <= k_inc;
            end
          end
        end

        ST_SKIP: begin
          if (r_fire && r_last) begin
            state_reg <= ST_LOAD;
            busy_reg  <= 1'b0;
          end
        end

        // ldr_rst was raised on the entry edge; hold it one more cycle, then release into start.
        ST_CORE_RST: begin
          if (!rst_cnt_reg) begin
            rst_cnt_reg <= 1'b1;
          end else begin
            ldr_rst_reg   <= 1'b0;
            ldr_start_reg <= 1'b1;
            solve_cnt_reg <= '0;
            state_reg     <= ST_SOLVE;
          end
        end

        ST_SOLVE: begin
          if (ldr_done) begin
            cycles_reg    <= solve_cnt_reg + 16'd1;
            ldr_start_reg <= 1'b0;
            state_reg     <= ST_DRAIN;
            k_reg         <= '0;
            a_valid_reg   <= 1'b1;
            a_data_reg    <= ldr_a[W-1:0];
            a_last_reg    <= (K_LAST == '0);
          end else begin
            solve_cnt_reg <= solve_cnt_reg + 16'd1;
`ifdef LDR_SEQ_TIMEOUT_EN
            if (solve_cnt_reg == 16'(TIMEOUT - 1)) begin
              frame_err_reg <= 1'b1;
              ldr_rst_reg   <= 1'b1;
              ldr_start_reg <= 1'b0;
              state_reg     <= ST_LOAD;
              k_reg         <= '0;
              ready_reg     <= 1'b1;
              busy_reg      <= 1'b0;
            end
`else
`endif
          end
        end

        ST_DRAIN: begin
          if (a_fire) begin
            if (k_reg == K_LAST) begin
              a_valid_reg <= 1'b0;
              a_last_reg  <= 1'b0;
              frames_reg  <= frames_reg + 16'd1;
              state_reg   <= ST_LOAD;
              ready_reg   <= 1'b1;
              busy_reg    <= 1'b0;
              k_reg       <= '0;
            end else begin
              k_reg      <= k_inc;
              a_data_reg <= cap_reg[k_inc*W +: W];
              a_last_reg <= (k_inc == K_LAST);
            end
          end
        end

        default: begin
          state_reg <= ST_LOAD;
        end
      endcase
    end
  end

  // Reset masks the outputs in the same cycle so the core sees an abort without waiting for an edge.
  assign r_ready   = ready_reg & ~reset;
  assign ldr_rst   = ldr_rst_reg | reset;
  assign ldr_start = ldr_start_reg & ~reset;
  assign ldr_r     = reset ? '0 : r_buf_reg;
  assign a_valid   = a_valid_reg & ~reset;
  assign a_data    = reset ? '0 : a_data_reg;
  assign a_last    = a_last_reg & ~reset;
  assign busy      = busy_reg & ~reset;
  assign frame_err = frame_err_reg & ~reset;
  assign cycles    = reset ? '0 : cycles_reg;
  assign frames    = reset ? '0 : frames_reg;

endmodule

// File: tb/tb_ldr_frame_sequencer.sv
// Scoreboard bench for ldr_frame_sequencer: directed frames push expected A words, a negedge monitor pops them.
module tb_ldr_frame_sequencer;
  localparam int W       = 16;
  localparam int ORDER   = 10;
  localparam int N       = ORDER + 1;
  localparam int TIMEOUT = 64;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           r_valid = 1'b0;
  logic [W-1:0]   r_data = '0;
  logic           r_last = 1'b0;
  logic           r_ready;
  logic           ldr_rst;
  logic           ldr_start;
  logic [N*W-1:0] ldr_r;
  logic [N*W-1:0] ldr_a = '0;
  logic           ldr_done = 1'b0;
  logic           a_valid;
  logic [W-1:0]   a_data;
  logic           a_last;
  logic           a_ready = 1'b0;
  logic           busy;
  logic           frame_err;
  logic [15:0]    cycles;
  logic [15:0]    frames;

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_data_q[$];
  logic         exp_last_q[$];
  logic         stall_prev = 1'b0;
  logic [W-1:0] data_prev = '0;
  logic         last_prev = 1'b0;

  ldr_frame_sequencer #(.W(W), .ORDER(ORDER), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .r_valid(r_valid), .r_data(r_data), .r_last(r_last), .r_ready(r_ready),
    .ldr_rst(ldr_rst), .ldr_start(ldr_start), .ldr_r(ldr_r), .ldr_a(ldr_a), .ldr_done(ldr_done),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .busy(busy), .frame_err(frame_err), .cycles(cycles), .frames(frames)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stability while stalled.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", a_valid, 1'b1);
        check("stall_data", a_data, data_prev);
        check("stall_last", a_last, last_prev);
      end
      if (a_valid) begin
        if (exp_data_q.size() == 0) begin
          check("a_unexpected", a_valid, 1'b0);
        end else if (a_ready) begin
          $display("A word %0h last=%0b", a_data, a_last);
          check("a_data", a_data, exp_data_q.pop_front());
          check("a_last", a_last, exp_last_q.pop_front());
        end
      end
      stall_prev <= a_valid && !a_ready;
      data_prev  <= a_data;
      last_prev  <= a_last;
    end
  end

  function automatic logic [N*W-1:0] exp_r(input logic [W-1:0] r0, input logic [W-1:0] step);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = r0 - W'(i) * step;
    return v;
  endfunction

  task automatic send_word(input logic [W-1:0] d, input logic last);
    logic fired;
    fired = 1'b0;
    r_valid = 1'b1;
    r_data = d;
    r_last = last;
    for (int i = 0; i < 64 && !fired; i++) begin
      @(negedge clk);
      fired = r_ready;
      @(posedge clk);
      #1;
    end
    r_valid = 1'b0;
    r_last = 1'b0;
    $display("R word %0h last=%0b", d, last);
    check("r_accept", fired, 1'b1);
  endtask

  task automatic send_frame(input logic [W-1:0] r0, input logic [W-1:0] step, input int n, input int last_idx);
    for (int i = 0; i < n; i++) send_word(r0 - W'(i) * step, (i + 1) == last_idx);
  endtask

  task automatic load_a(input logic [W-1:0] a0, input logic [W-1:0] astep);
    for (int k = 0; k < N; k++) begin
      ldr_a[k*W +: W] = a0 + W'(k) * astep;
      exp_data_q.push_back(a0 + W'(k) * astep);
      exp_last_q.push_back(k == ORDER);
    end
  endtask

  task automatic drain(input bit bp);
    int i;
    i = 0;
    while (a_valid && i < 200) begin
      check("r_ready_drain", r_ready, 1'b0);
      a_ready = bp ? (i % 3 == 0) : 1'b1;
      @(posedge clk);
      #1;
      i++;
    end
    a_ready = 1'b0;
    check("drain_bound", a_valid, 1'b0);
    check("drain_left", exp_data_q.size(), 0);
    check("r_ready_next", r_ready, 1'b1);
    check("busy_after", busy, 1'b0);
  endtask

  // Entered one cycle after the last R word was accepted (t+1).
  task automatic solve_and_drain(input logic [W-1:0] r0, input logic [W-1:0] step, input logic [W-1:0] a0,
                                 input logic [W-1:0] astep, input bit bp, input logic [15:0] exp_frames);
    check("r_buf", ldr_r, exp_r(r0, step));
    check("rst_t1", ldr_rst, 1'b1);
    check("start_t1", ldr_start, 1'b0);
    check("r_ready_t1", r_ready, 1'b0);
    @(posedge clk); #1;
    check("rst_t2", ldr_rst, 1'b1);
    check("start_t2", ldr_start, 1'b0);
    @(posedge clk); #1;
    check("rst_t3", ldr_rst, 1'b0);
    check("start_t3", ldr_start, 1'b1);
    load_a(a0, astep);
    repeat (199) @(posedge clk);
    #1;
    check("start_solve", ldr_start, 1'b1);
    check("busy_solve", busy, 1'b1);
    ldr_done = 1'b1;
    @(posedge clk); #1;
    ldr_done = 1'b0;
    check("a_valid_d1", a_valid, 1'b1);
    check("a0_d1", a_data, a0);
    check("cycles", cycles, 16'd200);
    check("start_off", ldr_start, 1'b0);
    drain(bp);
    check("frames", frames, exp_frames);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] nf;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ldr_rst", ldr_rst, 1'b1);
    check("rst_r_ready", r_ready, 1'b0);
    check("rst_start", ldr_start, 1'b0);
    check("rst_a_valid", a_valid, 1'b0);
    check("rst_a_last", a_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_cycles", cycles, 16'd0);
    check("rst_frames", frames, 16'd0);
    check("rst_ldr_r", ldr_r, '0);
    check("rst_a_data", a_data, 16'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("post_rst_ready", r_ready, 1'b1);
    @(posedge clk); #1;
    check("post_rst_ldr_rst", ldr_rst, 1'b0);
    check("post_rst_busy", busy, 1'b0);

    // Nominal frame.
    send_frame(16'h4000, 16'h1000, 11, 11);
    solve_and_drain(16'h4000, 16'h1000, 16'h1000, 16'h0101, 1'b0, 16'd1);

    // Short frame (r_last on word 5), then a normal frame drained under backpressure.
    send_frame(16'h0100, 16'h0010, 5, 5);
    check("ferr_short", frame_err, 1'b1);
    check("busy_short", busy, 1'b0);
    @(posedge clk); #1;
    check("ferr_short_pulse", frame_err, 1'b0);
    send_frame(16'h7000, 16'h0123, 11, 11);
    solve_and_drain(16'h7000, 16'h0123, 16'hF000, 16'h0011, 1'b1, 16'd2);

    // Long frame: 13 words, r_last on 13; words 12-13 dropped.
    for (int i = 0; i < 13; i++) begin
      send_word(16'h2222 - W'(i) * 16'h0101, i == 12);
      if (i == 10) begin
        check("ferr_long", frame_err, 1'b1);
        check("busy_skip", busy, 1'b1);
      end
      if (i == 11) check("ferr_long_pulse", frame_err, 1'b0);
    end
    check("busy_after_skip", busy, 1'b0);
    check("skip_no_write", ldr_r, exp_r(16'h2222, 16'h0101));
    send_frame(16'h1357, 16'h0002, 11, 11);
    solve_and_drain(16'h1357, 16'h0002, 16'h8001, 16'h0203, 1'b0, 16'd3);

    // Core never finishes.
    send_frame(16'h0F0F, 16'h0001, 11, 11);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("to_start", ldr_start, 1'b1);
`ifdef LDR_SEQ_TIMEOUT_EN
    repeat (63) @(posedge clk);
    #1;
    check("to_ferr_early", frame_err, 1'b0);
    check("to_busy_early", busy, 1'b1);
    @(posedge clk); #1;
    check("to_ferr", frame_err, 1'b1);
    check("to_ldr_rst", ldr_rst, 1'b1);
    check("to_start_off", ldr_start, 1'b0);
    check("to_busy", busy, 1'b0);
    check("to_r_ready", r_ready, 1'b1);
    @(posedge clk); #1;
    check("to_ferr_pulse", frame_err, 1'b0);
    check("to_ldr_rst_pulse", ldr_rst, 1'b0);
    check("to_cycles", cycles, 16'd200);
    nf = 16'd3;
`else
    repeat (150) @(posedge clk);
    #1;
    check("hang_busy", busy, 1'b1);
    check("hang_start", ldr_start, 1'b1);
    check("hang_r_ready", r_ready, 1'b0);
    check("hang_ferr", frame_err, 1'b0);
    load_a(16'h0F00, 16'h0001);
    ldr_done = 1'b1;
    @(posedge clk); #1;
    ldr_done = 1'b0;
    check("hang_cycles", cycles, 16'd151);
    drain(1'b0);
    nf = 16'd4;
`endif
    check("frames_after_to", frames, nf);

    // Reset mid-SOLVE at start+50.
    send_frame(16'h0AAA, 16'h0011, 11, 11);
    @(posedge clk); #1;
    @(posedge clk); #1;
    repeat (50) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_start", ldr_start, 1'b0);
    check("mid_rst_ldr_rst", ldr_rst, 1'b1);
    check("mid_rst_r_ready", r_ready, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("mid_rst_frames", frames, 16'd0);
    check("mid_rst_cycles", cycles, 16'd0);
    check("mid_rst_ldr_r", ldr_r, '0);
    check("mid_rst_ready", r_ready, 1'b1);
    check("mid_rst_busy_after", busy, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("mid_rst_idle_start", ldr_start, 1'b0);

    // Frame counter wrap.
    force dut.frames_reg = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frames_reg;
    @(posedge clk); #1;
    check("wrap_preload", frames, 16'hFFFF);
    send_frame(16'h5555, 16'h0300, 11, 11);
    solve_and_drain(16'h5555, 16'h0300, 16'h0042, 16'h1111, 1'b0, 16'h0000);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ldr_frame_sequencer.md
# ldr_frame_sequencer

Frame-level controller for the Levinson-Durbin recursion core. It collects one frame of ORDER+1 autocorrelation words from an upstream valid/ready stream and holds them stable on the core's R inputs. It then resets and starts the core, waits for `done`, and streams the ORDER+1 prediction coefficients out on a downstream valid/ready port. It sits between the autocorrelation stage and the coefficient consumer, replacing software-driven register pokes with hardware sequencing.

## Interface
Parameters:
- `W`, 16, word width of R and A values (signed).
- `ORDER`, 10, predictor order; frames are ORDER+1 words.
- `TIMEOUT`, 4096, maximum SOLVE cycles before abort (used only with the timeout feature).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `r_valid`  in  1  autocorrelation word valid.
- `r_data`  in  W  autocorrelation word R_k, k ascending from 0.
- `r_last`  in  1  marks R_ORDER.
- `r_ready`  out  1  sequencer accepts a word.
- `ldr_rst`  out  1  core reset.
- `ldr_start`  out  1  core start, level.
- `ldr_r`  out  (ORDER+1)*W  frame buffer; bits [k*W +: W] = R_k.
- `ldr_a`  in  (ORDER+1)*W  core coefficients; bits [k*W +: W] = A_k.
- `ldr_done`  in  1  core finished.
- `a_valid`  out  1  coefficient valid.
- `a_data`  out  W  coefficient A_k.
- `a_last`  out  1  marks A_ORDER.
- `a_ready`  in  1  downstream accepts.
- `busy`  out  1  high in any state other than LOAD.
- `frame_err`  out  1  one-cycle pulse on framing error or timeout.
- `cycles`  out  16  SOLVE cycle count of the last successful frame.
- `frames`  out  16  count of frames fully drained, wraps at 0xFFFF→0.

## Operation
- States: LOAD, SKIP, CORE_RST, SOLVE, DRAIN.
- **While `reset` is high:**
  - State goes to LOAD; word index `k`=0.
  - `ldr_rst`=1; `r_ready`, `ldr_start`, `a_valid`, `a_last`, `busy`, `frame_err` = 0.
  - `cycles`, `frames`, `ldr_r`, `a_data` = 0.
- **LOAD** (`r_ready`=1):
  - Each accepted word (`r_valid & r_ready`) writes `ldr_r` slot `k`, then `k`++.
  - Accepted word with `r_last` and `k`==ORDER: go to CORE_RST.
  - Accepted word with `r_last` and `k`<ORDER: pulse `frame_err`, set `k`=0, stay in LOAD.
  - Accepted word without `r_last` and `k`==ORDER: pulse `frame_err`, set `k`=0, go to SKIP.
- **SKIP** (`r_ready`=1): discard words up to and including the next `r_last`, then return to LOAD.
- **CORE_RST**: `ldr_rst`=1 for exactly 2 cycles, `r_ready`=0, then go to SOLVE.
- **SOLVE**:
  - `ldr_start`=1; internal count increments every cycle.
  - On `ldr_done`: latch `ldr_a` into the capture register; `cycles` ← count+1; `ldr_start`=0 from the next cycle; go to DRAIN with `k`=0.
- **DRAIN**:
  - `a_valid`=1; `a_data`=captured A_k; `a_last`=(`k`==ORDER).
  - On each `a_valid & a_ready`: `k`++.
  - On the handshake of A_ORDER: `frames`++, go to LOAD.
- Outputs hold stable while `a_valid & !a_ready`.
- `ldr_r` changes only in LOAD/SKIP; never during CORE_RST, SOLVE or DRAIN.
- SKIP discards words and never writes `ldr_r`.
- No overlap: upstream is stalled from the last accepted word until DRAIN ends.
- `reset` mid-operation aborts immediately; any partial frame or pending coefficients are lost.

## Timing
- Last R word accepted at cycle t:
  - `ldr_rst` high at t+1 and t+2.
  - `ldr_start` rises at t+3.
- `ldr_done` sampled high at cycle d: `a_valid` high with A_0 at d+1.
- Coefficient throughput: 1 word/cycle with `a_ready` held high, so DRAIN takes ORDER+1 cycles minimum.
- First R of the next frame can be accepted the cycle after the A_ORDER handshake.
- `frame_err` is registered and asserted the cycle after the offending handshake.
- `ldr_done` is ignored outside SOLVE.

## Configuration
- `LDR_SEQ_TIMEOUT_EN` defined:
  - In SOLVE, if the count reaches TIMEOUT-1 without `ldr_done`: pulse `frame_err`, assert `ldr_rst` for 1 cycle, go to LOAD with `k`=0.
  - No coefficients are output; `cycles` and `frames` are unchanged.
- Undefined: SOLVE waits indefinitely for `ldr_done`; `TIMEOUT` has no effect.

## Test plan
- **Nominal frame:** send R = 0x4000, 0x3000, …, `r_last` on word 11; core model gives `ldr_done` 200 cycles after start.
  - `ldr_rst` 2 cycles, then `ldr_start`.
  - 11 `a_data` words match the model in order; `a_last` on word 11 only.
  - `cycles`=200; `frames`=1.
- **Framing errors:**
  - `r_last` on word 5: `frame_err` pulse; the next 11-word frame solves normally.
  - 13 words with `r_last` on word 13: `frame_err` after word 11; words 12–13 dropped.
- **Backpressure:** toggle `a_ready` 1-in-3 during DRAIN → no word lost or duplicated; `a_data` stable while stalled; `r_ready`=0 throughout.
- **Reset mid-SOLVE:** assert `reset` for 1 cycle at start+50 → `ldr_start`=0 and `ldr_rst`=1 during the reset cycle; state returns to LOAD; `frames` = 0.
- **Timeout (`LDR_SEQ_TIMEOUT_EN`, TIMEOUT=64):** core never asserts `ldr_done` → `frame_err` at start+64, then back to LOAD; no `a_valid`. Without the macro, `busy` stays 1 indefinitely.
- **Counter wrap:** preload `frames`=0xFFFF via force, complete one frame → `frames`=0x0000.
